sram_responder: RTL and testbench
=================================

SRAM_RESPONDER -- requirements
Module: sram_responder

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 10, meaning storage depth of 2^ADDR_WIDTH 32-bit words.
REQ-002 The block SHALL have parameter WAIT_CYCLES, default 1, meaning wait states inserted before each response (0..15).
REQ-003 clk50  input  1  single clock; all logic on the rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 ramAddr_i  input  20  word address from the controller; only bits [ADDR_WIDTH-1:0] are used.
REQ-006 storeData_i  input  32  write data.
REQ-007 chipEnable_n_i  input  1  active-low chip select.
REQ-008 writeEnable_n_i  input  1  active-low write strobe.
REQ-009 readEnable_n_i  input  1  active-low output-enable (read) strobe.
REQ-010 LB_n_i  input  1  active-low lane enable for bits [15:0].
REQ-011 UB_n_i  input  1  active-low lane enable for bits [31:16].
REQ-012 loadData_o  output  32  registered read data.
REQ-013 loadValid_o  output  1  one-cycle pulse; loadData_o is valid.
REQ-014 writeAck_o  output  1  one-cycle pulse; write committed.
REQ-015 busy_o  output  1  high in every state except IDLE.
REQ-016 protoErr_o  output  1  one-cycle protocol-error pulse (see Configuration).

Function
REQ-017 The FSM SHALL have states IDLE, WAIT, RESP and HOLD.
REQ-018 In IDLE, with chipEnable_n_i=0 and exactly one of writeEnable_n_i/readEnable_n_i low at an edge, the block SHALL latch address, data, lane enables and direction.
- It SHALL go to WAIT if WAIT_CYCLES>0, else to RESP.
REQ-019 WAIT SHALL count exactly WAIT_CYCLES cycles, then go to RESP.
- Net effect: a request sampled at edge N produces its response pulse, visible after edge N+WAIT_CYCLES+1.
REQ-020 RESP, read: loadData_o SHALL carry the addressed word with disabled lanes forced to 0, and loadValid_o SHALL be 1 for one cycle.
REQ-021 RESP, write: only enabled lanes SHALL be updated, and writeAck_o SHALL be 1 for one cycle.
- With both lanes disabled, memory is unchanged but the ack still fires.
REQ-022 After RESP the FSM SHALL enter HOLD and stay there until chipEnable_n_i=1 is sampled, then return to IDLE.
- Back-to-back accesses therefore require CE deassertion for at least one cycle.
REQ-023 If chipEnable_n_i=1 is sampled in WAIT, the access SHALL abort to IDLE with no memory update and no pulse.
REQ-024 Address bits [19:ADDR_WIDTH] SHALL be ignored; addresses wrap modulo depth.
REQ-025 loadData_o SHALL hold its last value between reads.
REQ-026 Memory contents SHALL NOT be reset; unwritten locations read undefined.
REQ-027 Changes on any input during WAIT/RESP/HOLD SHALL NOT affect the latched access.

Reset
REQ-028 On rst=0, the FSM SHALL go to IDLE and the wait counter SHALL clear to 0, asynchronously.
REQ-029 On rst=0, all outputs SHALL be 0.
REQ-030 Reset asserted mid-access SHALL cancel the access; a write not yet in RESP SHALL NOT modify memory.

Configuration
REQ-031 With macro SRAM_RESPONDER_PROTO_CHECK_EN defined, the following SHALL apply in IDLE when chipEnable_n_i=0 with writeEnable_n_i=0 and readEnable_n_i=0 both sampled:
- protoErr_o SHALL pulse for one cycle.
- The request SHALL be ignored; the FSM enters HOLD.
REQ-032 Without the macro, protoErr_o SHALL be tied 0 and the same condition SHALL be treated as a write (write priority).

Verification
REQ-033 WAIT_CYCLES=1: write 32'hDEADBEEF to 0x00010 with both lanes enabled, CE high, then read 0x00010 -> writeAck_o pulse 2 cycles after request; loadValid_o pulse 2 cycles after read request; loadData_o=32'hDEADBEEF.
REQ-034 Lane masking: write 32'h11223344 to 0x5, then write 32'hAAAABBBB with UB_n_i=0 and LB_n_i=1, then read 0x5 -> 32'hAAAA3344; a read with LB_n_i=0 only returns 32'h00003344.
REQ-035 Wrap: ADDR_WIDTH=10, write 32'h12345678 to 0x00403, read 0x00003 -> 32'h12345678.
REQ-036 Abort: WAIT_CYCLES=3, write 32'hFFFFFFFF to 0x7 (holding 32'h0), deassert CE one cycle after request -> no writeAck_o; read 0x7 -> 32'h0.
REQ-037 Reset in WAIT during a write sets busy_o=0 and all outputs to 0 immediately; with SRAM_RESPONDER_PROTO_CHECK_EN, both strobes low -> protoErr_o=1 for one cycle and no ack.

Source files
------------

// File: rtl/sram_responder.sv
// Word-addressed SRAM with a strobe handshake, WAIT_CYCLES wait states, byte-lane masks and a HOLD state that lasts until CE is released.
// Optional feature macro SRAM_RESPONDER_PROTO_CHECK_EN: a request with both strobes low raises protoErr_o instead of being taken as a write.
module sram_responder #(
    parameter int ADDR_WIDTH  = 10,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk50,
    input  logic        rst,
    input  logic [19:0] ramAddr_i,
    input  logic [31:0] storeData_i,
    input  logic        chipEnable_n_i,
    input  logic        writeEnable_n_i,
    input  logic        readEnable_n_i,
    input  logic        LB_n_i,
    input  logic        UB_n_i,
    output logic [31:0] loadData_o,
    output logic        loadValid_o,
    output logic        writeAck_o,
    output logic        busy_o,
    output logic        protoErr_o
);
    localparam int         DEPTH     = 1 << ADDR_WIDTH;
    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_WAIT    = 2'd1;
    localparam logic [1:0] S_RESP    = 2'd2;
    localparam logic [1:0] S_HOLD    = 2'd3;
    localparam logic [3:0] WAIT_LAST = 4'(WAIT_CYCLES - 1);

    logic [1:0]            state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [31:0]           data_q, data_d;
    logic [31:0]           mask_q, mask_d;
    logic                  wr_q, wr_d;
    logic [31:0]           load_q, load_d;
    logic                  valid_q, valid_d;
    logic                  ack_q, ack_d;
    logic                  perr_q, perr_d;
    logic [31:0]           mem [DEPTH];

    logic accept;
    logic proto_err;
    logic unused_addr;

    // Upper address bits are don't-care; the depth wraps.
    assign unused_addr = ^ramAddr_i;

`ifdef SRAM_RESPONDER_PROTO_CHECK_EN
    assign proto_err = ~chipEnable_n_i & ~writeEnable_n_i & ~readEnable_n_i;
    assign accept    = ~chipEnable_n_i & (writeEnable_n_i ^ readEnable_n_i);
`else
    assign proto_err = 1'b0;
    assign accept    = ~chipEnable_n_i & ~(writeEnable_n_i & readEnable_n_i);
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        data_d  = data_q;
        mask_d  = mask_q;
        wr_d    = wr_q;
        load_d  = load_q;
        valid_d = 1'b0;
        ack_d   = 1'b0;
        perr_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    addr_d  = ramAddr_i[ADDR_WIDTH-1:0];
                    data_d  = storeData_i;
                    mask_d  = {{16{~UB_n_i}}, {16{~LB_n_i}}};
                    wr_d    = ~writeEnable_n_i;
                    cnt_d   = 4'd0;
                    state_d = (WAIT_CYCLES > 0) ? S_WAIT : S_RESP;
                end else if (proto_err) begin
                    perr_d  = 1'b1;
                    state_d = S_HOLD;
                end
            end
            S_WAIT: begin
                if (chipEnable_n_i) begin
                    cnt_d   = 4'd0;
                    state_d = S_IDLE;
                end else if (cnt_q == WAIT_LAST) begin
                    cnt_d   = 4'd0;
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            S_RESP: begin
                state_d = S_HOLD;
                if (wr_q) begin
                    ack_d = 1'b1;
                end else begin
                    valid_d = 1'b1;
                    load_d  = mem[addr_q] & mask_q;
                end
            end
            default: begin
                if (chipEnable_n_i) state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk50 or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= '0;
            data_q  <= 32'd0;
            mask_q  <= 32'd0;
            wr_q    <= 1'b0;
            load_q  <= 32'd0;
            valid_q <= 1'b0;
            ack_q   <= 1'b0;
            perr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            mask_q  <= mask_d;
            wr_q    <= wr_d;
            load_q  <= load_d;
            valid_q <= valid_d;
            ack_q   <= ack_d;
            perr_q  <= perr_d;
        end
    end

    // Storage is not reset; reset clears state_q so a pending write never commits.
    always_ff @(posedge clk50) begin
        if (state_q == S_RESP && wr_q) begin
            mem[addr_q] <= (mem[addr_q] & ~mask_q) | (data_q & mask_q);
        end
    end

    assign loadData_o  = load_q;
    assign loadValid_o = valid_q;
    assign writeAck_o  = ack_q;
    assign busy_o      = (state_q != S_IDLE);
    assign protoErr_o  = perr_q;
endmodule

// File: tb/tb_sram_responder.sv
// Randomised bench for sram_responder: lane-aware memory model plus a pulse scoreboard that checks both the timing and the data of every response.
module tb_sram_responder;
    localparam int AW = 10;
    localparam int W  = 3;

    logic        clk50 = 1'b0;
    logic        rst   = 1'b0;
    logic [19:0] ramAddr_i = '0;
    logic [31:0] storeData_i = '0;
    logic        chipEnable_n_i = 1'b1;
    logic        writeEnable_n_i = 1'b1;
    logic        readEnable_n_i = 1'b1;
    logic        LB_n_i = 1'b1;
    logic        UB_n_i = 1'b1;
    logic [31:0] loadData_o;
    logic        loadValid_o, writeAck_o, busy_o, protoErr_o;

    sram_responder #(.ADDR_WIDTH(AW), .WAIT_CYCLES(W)) dut (
        .clk50(clk50), .rst(rst), .ramAddr_i(ramAddr_i), .storeData_i(storeData_i),
        .chipEnable_n_i(chipEnable_n_i), .writeEnable_n_i(writeEnable_n_i),
        .readEnable_n_i(readEnable_n_i), .LB_n_i(LB_n_i), .UB_n_i(UB_n_i),
        .loadData_o(loadData_o), .loadValid_o(loadValid_o), .writeAck_o(writeAck_o),
        .busy_o(busy_o), .protoErr_o(protoErr_o)
    );

    always #5 clk50 = ~clk50;

    int edge_cnt = 0;
    always @(posedge clk50) edge_cnt <= edge_cnt + 1;

    // kind: 1 = read data, 2 = write ack, 4 = protocol error
    typedef struct {
        logic [2:0]  kind;
        int          at_edge;
        logic [31:0] data;
        logic [31:0] chk;
    } exp_t;
    exp_t sbq[$];

    logic [31:0] mem_m   [1 << AW];
    logic [31:0] known_m [1 << AW];

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp,
                         input logic [31:0] m);
        checks++;
        if ((act & m) !== (exp & m)) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (mask %h) at edge %0d", name, act, exp, m, edge_cnt);
        end
    endtask

    // Monitor: every response pulse must match the oldest expectation; otherwise the read data must hold.
    logic [31:0] hold_exp = 32'd0;
    logic [31:0] hold_chk = 32'hFFFF_FFFF;
    initial begin
        forever begin
            @(negedge clk50);
            if (!rst) begin
                hold_exp = 32'd0;
                hold_chk = 32'hFFFF_FFFF;
            end else if (loadValid_o || writeAck_o || protoErr_o) begin
                if (sbq.size() == 0) begin
                    check("unexpected_pulse", {29'd0, protoErr_o, writeAck_o, loadValid_o}, 32'd0, 32'hFFFF_FFFF);
                end else begin
                    exp_t e;
                    e = sbq.pop_front();
                    check("pulse_kind", {29'd0, protoErr_o, writeAck_o, loadValid_o}, {29'd0, e.kind}, 32'hFFFF_FFFF);
                    check("pulse_edge", edge_cnt, e.at_edge, 32'hFFFF_FFFF);
                    if (e.kind == 3'd1) begin
                        check("read_data", loadData_o, e.data, e.chk);
                        hold_exp = e.data;
                        hold_chk = e.chk;
                    end
                end
            end else begin
                check("data_hold", loadData_o, hold_exp, hold_chk);
            end
        end
    end

    task automatic scramble();
        ramAddr_i       = 20'($urandom);
        storeData_i     = $urandom;
        writeEnable_n_i = 1'($urandom);
        readEnable_n_i  = 1'($urandom);
        LB_n_i          = 1'($urandom);
        UB_n_i          = 1'($urandom);
    endtask

    // One complete access; the model and scoreboard are updated as the request is presented.
    task automatic do_req(input logic we_n, input logic re_n, input logic [19:0] a,
                          input logic [31:0] d, input logic ub_n, input logic lb_n, input bit abort);
        logic [31:0] mask;
        int          idx;
        int          req_edge;
        bit          is_proto;
        exp_t        e;
        @(negedge clk50);
        chipEnable_n_i  = 1'b0;
        writeEnable_n_i = we_n;
        readEnable_n_i  = re_n;
        ramAddr_i       = a;
        storeData_i     = d;
        UB_n_i          = ub_n;
        LB_n_i          = lb_n;
        req_edge = edge_cnt + 1;
        mask     = {{16{~ub_n}}, {16{~lb_n}}};
        idx      = int'(a % (20'd1 << AW));
        is_proto = 1'b0;
`ifdef SRAM_RESPONDER_PROTO_CHECK_EN
        is_proto = !we_n && !re_n;
`endif
        if (is_proto) begin
            e.kind = 3'd4; e.at_edge = req_edge; e.data = '0; e.chk = '0;
            sbq.push_back(e);
        end else if (!abort) begin
            e.at_edge = req_edge + W + 1;
            if (!we_n) begin
                mem_m[idx]   = (mem_m[idx] & ~mask) | (d & mask);
                known_m[idx] = known_m[idx] | mask;
                e.kind = 3'd2; e.data = '0; e.chk = '0;
            end else begin
                e.kind = 3'd1;
                e.data = mem_m[idx] & mask;
                e.chk  = ~mask | (known_m[idx] & mask);
            end
            sbq.push_back(e);
        end
        @(negedge clk50);
        check("busy_after_req", {31'd0, busy_o}, 32'd1, 32'hFFFF_FFFF);
        if (abort) begin
            scramble();
            chipEnable_n_i = 1'b1;
            @(negedge clk50);
            check("busy_after_abort", {31'd0, busy_o}, 32'd0, 32'hFFFF_FFFF);
        end else begin
            repeat (W + 1) begin
                scramble();
                @(negedge clk50);
            end
            chipEnable_n_i = 1'b1;
            @(negedge clk50);
        end
    endtask

    task automatic check_outputs_zero(input string name);
        check(name, {loadData_o[31:0]}, 32'd0, 32'hFFFF_FFFF);
        check({name, "_ctl"}, {28'd0, loadValid_o, writeAck_o, busy_o, protoErr_o}, 32'd0, 32'hFFFF_FFFF);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete, expected finish before 1000000");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < (1 << AW); i++) begin
            mem_m[i]   = 32'd0;
            known_m[i] = 32'd0;
        end
        repeat (3) @(negedge clk50);
        check_outputs_zero("reset_state");
        rst = 1'b1;
        @(negedge clk50);

        // Basic write/read, lane masking, wrap, abort.
        do_req(1'b0, 1'b1, 20'h00010, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0);
        do_req(1'b1, 1'b0, 20'h00010, 32'h0,        1'b0, 1'b0, 1'b0);
        do_req(1'b0, 1'b1, 20'h00005, 32'h11223344, 1'b0, 1'b0, 1'b0);
        do_req(1'b0, 1'b1, 20'h00005, 32'hAAAABBBB, 1'b0, 1'b1, 1'b0);
        do_req(1'b1, 1'b0, 20'h00005, 32'h0,        1'b0, 1'b0, 1'b0);
        do_req(1'b1, 1'b0, 20'h00005, 32'h0,        1'b1, 1'b0, 1'b0);
        do_req(1'b0, 1'b1, 20'h00403, 32'h12345678, 1'b0, 1'b0, 1'b0);
        do_req(1'b1, 1'b0, 20'h00003, 32'h0,        1'b0, 1'b0, 1'b0);
        do_req(1'b0, 1'b1, 20'h00007, 32'h00000000, 1'b0, 1'b0, 1'b0);
        do_req(1'b0, 1'b1, 20'h00007, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b1);
        do_req(1'b1, 1'b0, 20'h00007, 32'h0,        1'b0, 1'b0, 1'b0);
        do_req(1'b0, 1'b1, 20'h00007, 32'h55AA55AA, 1'b1, 1'b1, 1'b0);
        do_req(1'b1, 1'b0, 20'h00007, 32'h0,        1'b0, 1'b0, 1'b0);
        do_req(1'b0, 1'b0, 20'h00009, 32'h0BADF00D, 1'b0, 1'b0, 1'b0);
        do_req(1'b1, 1'b0, 20'h00009, 32'h0,        1'b0, 1'b0, 1'b0);

        // Reset in WAIT during a write: outputs clear immediately and memory keeps its old value.
        @(negedge clk50);
        chipEnable_n_i = 1'b0; writeEnable_n_i = 1'b0; readEnable_n_i = 1'b1;
        ramAddr_i = 20'h00007; storeData_i = 32'hCAFEF00D; UB_n_i = 1'b0; LB_n_i = 1'b0;
        @(negedge clk50);
        check("busy_before_reset", {31'd0, busy_o}, 32'd1, 32'hFFFF_FFFF);
        #2 rst = 1'b0;
        #1 check_outputs_zero("reset_mid_access");
        @(negedge clk50);
        chipEnable_n_i = 1'b1;
        #2 rst = 1'b1;
        do_req(1'b1, 1'b0, 20'h00007, 32'h0, 1'b0, 1'b0, 1'b0);

        // Random traffic over 16 locations, with random upper address bits to exercise the wrap.
        for (int n = 0; n < 300; n++) begin
            logic [19:0] a;
            int r;
            a = 20'($urandom);
            a[9:4] = '0;
            r = $urandom_range(0, 9);
            if (r < 4)       do_req(1'b0, 1'b1, a, $urandom, 1'($urandom), 1'($urandom), 1'b0);
            else if (r < 8)  do_req(1'b1, 1'b0, a, $urandom, 1'($urandom), 1'($urandom), 1'b0);
            else if (r == 8) do_req(1'b0, 1'b0, a, $urandom, 1'($urandom), 1'($urandom), 1'b0);
            else             do_req(1'b0, 1'b1, a, $urandom, 1'($urandom), 1'($urandom), 1'b1);
        end

        repeat (W + 4) @(negedge clk50);
        check("scoreboard_empty", sbq.size(), 32'd0, 32'hFFFF_FFFF);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
